mac_accumulator: RTL and testbench

Downstream consumer of the 8x8 Booth multiplier array. Takes signed 16-bit products over a valid/ready handshake and sign-extends them into an ACC_W-bit accumulator. After N_TERMS products it presents the dot-product result plus an overflow flag on an output handshake. It also provides the registered, back-pressurable boundary between the combinational multiplier and the rest of the datapath.

---
 rtl/mac_accumulator.sv | 115 +++++++++++
 tb/tb_mac_accumulator.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator.sv
// Dot-product accumulator behind the 8x8 Booth multiplier: sums N_TERMS signed products and returns the total with a sticky overflow flag.
// Optional build macro MAC_SAT_EN: when defined the accumulator saturates on overflow; when undefined it wraps modulo 2^ACC_W.
module mac_accumulator #(
  parameter int ACC_W   = 24,
  parameter int N_TERMS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [15:0]      in_prod,
  input  logic                    clear,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_acc,
  output logic                    out_ovf,
  output logic                    dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
  // the producer holds data stable while valid=1 and ready=0, and ready never depends
  // combinationally on the partner's valid.

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  localparam logic [7:0]               LAST    = 8'(N_TERMS - 1);
  localparam logic signed [ACC_W-1:0]  ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]  ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t                    state;
  logic signed [ACC_W-1:0]   acc;
  logic [7:0]                cnt;
  logic                      ovf;

  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   sum;
  logic signed [ACC_W-1:0]   acc_next;
  logic                      add_ovf;
  logic                      accept;

  assign dbg_state = state;
  assign accept    = in_valid && in_ready;
  assign prod_ext  = {{(ACC_W-16){in_prod[15]}}, in_prod};
  assign sum       = acc + prod_ext;
  // Signed overflow: operands share a sign and the sum's sign differs from it.
  assign add_ovf   = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);

  always_comb begin
    acc_next = sum;
`ifdef MAC_SAT_EN
    if (add_ovf) begin
      acc_next = acc[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end
`else
    acc_next = sum;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_ACC;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_ovf   <= 1'b0;
      in_ready  <= 1'b0;
    end else if (clear) begin
      state     <= ST_ACC;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        ST_ACC: begin
          in_ready <= 1'b1;
          if (accept) begin
            acc <= acc_next;
            cnt <= cnt + 8'd1;
            ovf <= ovf | add_ovf;
            if (cnt == LAST) begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
              out_acc   <= acc_next;
              out_ovf   <= ovf | add_ovf;
              in_ready  <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          in_ready <= 1'b0;
          if (out_valid && out_ready) begin
            state     <= ST_ACC;
            out_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state    <= ST_ACC;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: three instances (N=4/W=24, N=5/W=18, N=2/W=24) share clock and reset.
module tb_mac_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]         in_valid  = '0;
  logic [2:0]         clear     = '0;
  logic [2:0]         out_ready = '0;
  logic signed [15:0] in_prod [3];
  logic [2:0]         in_ready;
  logic [2:0]         out_valid;
  logic [2:0]         out_ovf;
  logic [2:0]         dbg_state;
  logic signed [23:0] acc0;
  logic signed [17:0] acc1;
  logic signed [23:0] acc2;

  int errors = 0;
  int checks = 0;

  mac_accumulator #(.ACC_W(24), .N_TERMS(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_prod(in_prod[0]), .clear(clear[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_acc(acc0), .out_ovf(out_ovf[0]), .dbg_state(dbg_state[0]));

  mac_accumulator #(.ACC_W(18), .N_TERMS(5)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_prod(in_prod[1]), .clear(clear[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_acc(acc1), .out_ovf(out_ovf[1]), .dbg_state(dbg_state[1]));

  mac_accumulator #(.ACC_W(24), .N_TERMS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_prod(in_prod[2]), .clear(clear[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_acc(acc2), .out_ovf(out_ovf[2]), .dbg_state(dbg_state[2]));

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int get_acc(input int d);
    case (d)
      0:       return int'(acc0);
      1:       return int'(acc1);
      default: return int'(acc2);
    endcase
  endfunction

  // Called 1 time unit after a rising edge; returns 1 time unit after the accepting edge.
  task automatic push(input int d, input int val);
    int waited = 0;
    while (!in_ready[d] && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready[d]) check("push_ready_timeout", int'(in_ready[d]), 1);
    in_valid[d] = 1'b1;
    in_prod[d]  = 16'(val);
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic expect_result(input string tag, input int d, input int acc_exp, input int ovf_exp);
    check({tag, "_valid"}, int'(out_valid[d]), 1);
    check({tag, "_acc"}, get_acc(d), acc_exp);
    check({tag, "_ovf"}, int'(out_ovf[d]), ovf_exp);
    check({tag, "_ready_low"}, int'(in_ready[d]), 0);
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) in_prod[i] = '0;
    #2;
    check("rst_valid", int'(out_valid[0]), 0);
    check("rst_acc", get_acc(0), 0);
    check("rst_ovf", int'(out_ovf[0]), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    step();
    check("rst_ready_after_release", int'(in_ready[0]), 1);
    out_ready = 3'b111;

    // Basic group
    push(0, 100); push(0, -50); push(0, 7); push(0, 3);
    expect_result("basic", 0, 60, 0);
    step();
    check("basic_valid_drop", int'(out_valid[0]), 0);
    check("basic_ready_back", int'(in_ready[0]), 1);
    check("basic_acc_kept", get_acc(0), 60);

    // Backpressure with ignored input
    out_ready[0] = 1'b0;
    push(0, 100); push(0, -50); push(0, 7); push(0, 3);
    in_valid[0] = 1'b1;
    in_prod[0]  = 16'sd999;
    for (int c = 0; c < 5; c++) begin
      check("bp_valid_hold", int'(out_valid[0]), 1);
      check("bp_acc_hold", get_acc(0), 60);
      check("bp_ready_low", int'(in_ready[0]), 0);
      step();
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    step();
    check("bp_valid_drop", int'(out_valid[0]), 0);
    push(0, 1); push(0, 2); push(0, 3); push(0, 4);
    expect_result("bp_next", 0, 10, 0);
    step();

    // Overflow on the narrow instance
    for (int k = 0; k < 5; k++) push(1, 32767);
`ifdef MAC_SAT_EN
    expect_result("ovf", 1, 131071, 1);
`else
    expect_result("ovf", 1, -98309, 1);
`endif
    step();
    for (int k = 0; k < 5; k++) push(1, 1);
    expect_result("ovf_cleared", 1, 5, 0);
    step();

    // Negative extremes, sign extension
    push(2, -16256); push(2, -16256);
    expect_result("neg", 2, -32512, 0);
    step();

    // Clear drops partial group and the coincident product
    push(0, 10); push(0, 20);
    clear[0]    = 1'b1;
    in_valid[0] = 1'b1;
    in_prod[0]  = 16'sd30;
    step();
    clear[0]    = 1'b0;
    in_valid[0] = 1'b0;
    check("clear_no_valid", int'(out_valid[0]), 0);
    push(0, 1); push(0, 2); push(0, 3); push(0, 4);
    expect_result("clear", 0, 10, 0);
    step();

    // Asynchronous reset mid-group
    push(0, 5); push(0, 6);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", int'(out_valid[0]), 0);
    check("arst_acc", get_acc(0), 0);
    #3 rst_n = 1'b1;
    step();
    push(0, 1); push(0, 1); push(0, 1); push(0, 1);
    expect_result("post_rst", 0, 4, 0);
    step();
    check("post_rst_ready", int'(in_ready[0]), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    check("global_timeout", 0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
